// File: rtl/wb_dest_pipe.sv
// Write-back destination pipeline: picks the destination register at decode,
// carries {dst, we} through DEPTH stages with stall/flush handling, and gives
// per-stage RAW compares against the decode sources for the hazard unit.

// One tracked stage: {dst, we} register with a load enable, plus its
// compares against the two decode sources.
module wb_dest_stage #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] nxt_dst,
  input  logic          nxt_we,
  input  logic [AW-1:0] rs_src,
  input  logic [AW-1:0] rt_src,
  output logic [AW-1:0] dst,
  output logic          we,
  output logic          haz_rs,
  output logic          haz_rt
);

  // Stage register; reset discards the entry, load=0 holds it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dst <= '0;
      we  <= 1'b0;
    end else if (load) begin
      dst <= nxt_dst;
      we  <= nxt_we;
    end
  end

  // $0 is never a real dependency, even when a stage carries dst=0.
  always_comb begin
    haz_rs = we && (dst == rs_src) && (rs_src != '0);
    haz_rt = we && (dst == rt_src) && (rt_src != '0);
  end

endmodule

module wb_dest_pipe #(
  parameter int          AW       = 5,
  parameter int          DEPTH    = 3,
  parameter logic [AW-1:0] LINK_REG = 31,
  localparam int         CW       = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          dst_sel,
  input  logic [AW-1:0]       rt,
  input  logic [AW-1:0]       rd,
  input  logic                reg_write,
  input  logic                stall,
  input  logic                flush,
  input  logic [AW-1:0]       rs_src,
  input  logic [AW-1:0]       rt_src,
  output logic [DEPTH*AW-1:0] stage_dst,
  output logic [DEPTH-1:0]    stage_we,
  output logic [AW-1:0]       wb_addr,
  output logic                wb_we,
  output logic [DEPTH-1:0]    haz_rs,
  output logic [DEPTH-1:0]    haz_rt,
  output logic [CW-1:0]       inflight
);

  logic [AW-1:0]             sel_addr;
  logic                      sel_we;
  logic [DEPTH-1:0][AW-1:0]  dst_q;
  logic [DEPTH-1:0][AW-1:0]  nxt_dst;
  logic [DEPTH-1:0]          nxt_we;
  logic [DEPTH-1:0]          load;

  // Decode-side destination select; writes to $0 are dropped here so they
  // never show up as in-flight or as hazards.
  always_comb begin
    sel_addr = '0;
    case (dst_sel)
      2'b00:   sel_addr = rt;
      2'b01:   sel_addr = rd;
      2'b10:   sel_addr = LINK_REG;
      default: sel_addr = '0;
    endcase
    sel_we = reg_write && (dst_sel != 2'b11) && (sel_addr != '0);
  end

  // Next-state steering: flush beats stall at stage 0, a stall bubbles
  // stage 1, and everything from stage 2 onward keeps draining.
  always_comb begin
    nxt_dst = '0;
    nxt_we  = '0;
    load    = '1;
    // stage 0
    load[0] = flush || !stall;
    if (!flush) begin
      nxt_dst[0] = sel_addr;
      nxt_we[0]  = sel_we;
    end
    // stage 1
    if (!(stall && !flush)) begin
      nxt_dst[1] = dst_q[0];
      nxt_we[1]  = stage_we[0];
    end
    // stages 2..DEPTH-1
    for (int i = 2; i < DEPTH; i++) begin
      nxt_dst[i] = dst_q[i-1];
      nxt_we[i]  = stage_we[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    wb_dest_stage #(.AW(AW)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[g]),
      .nxt_dst (nxt_dst[g]),
      .nxt_we  (nxt_we[g]),
      .rs_src  (rs_src),
      .rt_src  (rt_src),
      .dst     (dst_q[g]),
      .we      (stage_we[g]),
      .haz_rs  (haz_rs[g]),
      .haz_rt  (haz_rt[g])
    );
  end

  assign stage_dst = dst_q;
  assign wb_addr   = dst_q[DEPTH-1];
  assign wb_we     = stage_we[DEPTH-1];

  // Number of stages that will still write the register file.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < DEPTH; i++)
      inflight = inflight + CW'(stage_we[i]);
  end

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Bench for wb_dest_pipe: directed scenarios plus random traffic, all checked
// against a list-of-entries reference model.
module tb_wb_dest_pipe;
  localparam int AW = 5;
  localparam int DEPTH = 3;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 0;
  logic rst_n, reg_write, stall, flush;
  logic [1:0] dst_sel;
  logic [AW-1:0] rt, rd, rs_src, rt_src, wb_addr;
  logic [DEPTH*AW-1:0] stage_dst;
  logic [DEPTH-1:0] stage_we, haz_rs, haz_rt;
  logic wb_we;
  logic [CW-1:0] inflight;

  int n_chk = 0;
  int n_err = 0;

  // reference: one entry per stage, index 0 = youngest
  logic [AW-1:0] m_dst [DEPTH];
  logic          m_we  [DEPTH];

  wb_dest_pipe #(.AW(AW), .DEPTH(DEPTH), .LINK_REG(5'd31)) dut (
    .clk(clk), .rst_n(rst_n), .dst_sel(dst_sel), .rt(rt), .rd(rd),
    .reg_write(reg_write), .stall(stall), .flush(flush),
    .rs_src(rs_src), .rt_src(rt_src), .stage_dst(stage_dst),
    .stage_we(stage_we), .wb_addr(wb_addr), .wb_we(wb_we),
    .haz_rs(haz_rs), .haz_rt(haz_rt), .inflight(inflight));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every output against the model and the current sources.
  task automatic check_all();
    logic [DEPTH-1:0] e_rs, e_rt;
    int cnt;
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("dst%0d", i), stage_dst[i*AW +: AW], m_dst[i]);
      chk($sformatf("we%0d", i), stage_we[i], m_we[i]);
      e_rs[i] = m_we[i] && m_dst[i] == rs_src && rs_src != 0;
      e_rt[i] = m_we[i] && m_dst[i] == rt_src && rt_src != 0;
      if (m_we[i]) cnt++;
    end
    chk("wb_addr", wb_addr, m_dst[DEPTH-1]);
    chk("wb_we", wb_we, m_we[DEPTH-1]);
    chk("haz_rs", haz_rs, e_rs);
    chk("haz_rt", haz_rt, e_rt);
    chk("inflight", inflight, cnt);
  endtask

  // Drive one cycle's inputs, check outputs before the edge, then advance
  // the model by the same edge.
  task automatic step(input logic r, input logic [1:0] ds, input logic [AW-1:0] t,
                      input logic [AW-1:0] d, input logic rw, input logic st,
                      input logic fl, input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    logic [AW-1:0] a;
    logic          w;
    @(negedge clk);
    rst_n = r; dst_sel = ds; rt = t; rd = d; reg_write = rw;
    stall = st; flush = fl; rs_src = s1; rt_src = s2;
    #1 check_all();
    @(posedge clk);
    a = (ds == 0) ? t : (ds == 1) ? d : (ds == 2) ? 5'd31 : 5'd0;
    w = rw && ds != 3 && a != 0;
    if (!r) begin
      for (int i = 0; i < DEPTH; i++) begin m_dst[i] = 0; m_we[i] = 0; end
    end else begin
      for (int i = DEPTH - 1; i >= 2; i--) begin m_dst[i] = m_dst[i-1]; m_we[i] = m_we[i-1]; end
      if (st && !fl) begin m_dst[1] = 0; m_we[1] = 0; end
      else begin m_dst[1] = m_dst[0]; m_we[1] = m_we[0]; end
      if (fl) begin m_dst[0] = 0; m_we[0] = 0; end
      else if (!st) begin m_dst[0] = a; m_we[0] = w; end
    end
    #1;
  endtask

  task automatic idle();
    step(1, 2'b11, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_dst[i] = 0; m_we[i] = 0; end
    rst_n = 0; dst_sel = 3; rt = 0; rd = 0; reg_write = 0;
    stall = 0; flush = 0; rs_src = 0; rt_src = 0;
    @(posedge clk); #1;
    step(0, 3, 0, 0, 0, 0, 0, 0, 0);

    // reset with stall held after filling the pipe
    step(1, 1, 0, 7, 1, 0, 0, 0, 0);
    step(1, 1, 0, 9, 1, 0, 0, 0, 0);
    step(1, 0, 6, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 11, 1, 1, 0, 0, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_stage_we", stage_we, 0);
    chk("rst_inflight", inflight, 0);

    // mode select: rd=9, rt=4, link -> wb 9, 4, 31
    step(1, 1, 0, 9, 1, 0, 0, 0, 0);
    step(1, 0, 4, 0, 1, 0, 0, 0, 0);
    step(1, 2, 0, 0, 1, 0, 0, 0, 0);
    chk("mode_wb_rd", {wb_we, wb_addr}, {1'b1, 5'd9});
    idle();
    chk("mode_wb_rt", {wb_we, wb_addr}, {1'b1, 5'd4});
    idle();
    chk("mode_wb_link", {wb_we, wb_addr}, {1'b1, 5'd31});
    idle(); idle();

    // $0 and no-write
    step(1, 1, 0, 0, 1, 0, 0, 0, 0);
    chk("zero_we", stage_we[0], 0);
    step(1, 3, 7, 0, 1, 0, 0, 0, 0);
    chk("nowr_we", stage_we[0], 0);
    chk("nowr_inflight", inflight, 0);
    idle(); idle();

    // stall two cycles with rd=12 in stage 0
    step(1, 1, 0, 12, 1, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 1, 0, 0, 0);
    step(1, 3, 0, 0, 0, 1, 0, 0, 0);
    chk("stall_hold", {stage_we[0], stage_dst[0 +: AW]}, {1'b1, 5'd12});
    chk("stall_bubble", {stage_we[1], stage_dst[AW +: AW]}, 6'd0);
    idle();
    chk("stall_early_wb", wb_we, 0);
    idle();
    chk("stall_wb", {wb_we, wb_addr}, {1'b1, 5'd12});
    idle(); idle();

    // stall+flush: flush wins, no bubble
    step(1, 1, 0, 5, 1, 0, 0, 0, 0);
    step(1, 1, 0, 6, 1, 1, 1, 0, 0);
    chk("fl_s0", {stage_we[0], stage_dst[0 +: AW]}, 6'd0);
    chk("fl_s1", {stage_we[1], stage_dst[AW +: AW]}, {1'b1, 5'd5});
    idle(); idle();

    // hazards: stages hold 8, 8, 3
    step(1, 1, 0, 3, 1, 0, 0, 0, 0);
    step(1, 1, 0, 8, 1, 0, 0, 0, 0);
    step(1, 1, 0, 8, 1, 0, 0, 0, 0);
    rs_src = 8; rt_src = 3; stall = 1; #1;
    chk("haz_rs_dir", haz_rs, 3'b011);
    chk("haz_rt_dir", haz_rt, 3'b100);
    chk("haz_inflight", inflight, 3);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] s1, s2;
      s1 = $urandom_range(3, 0) == 0 ? m_dst[$urandom_range(DEPTH-1, 0)] : AW'($urandom);
      s2 = $urandom_range(3, 0) == 0 ? m_dst[$urandom_range(DEPTH-1, 0)] : AW'($urandom);
      step($urandom_range(40, 0) != 0, 2'($urandom), AW'($urandom_range(3, 0)),
           AW'($urandom), $urandom_range(4, 0) != 0, $urandom_range(4, 0) == 0,
           $urandom_range(7, 0) == 0, s1, s2);
    end
    @(negedge clk); #1 check_all();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_dest_pipe.md
# wb_dest_pipe

Parametrised successor to the single-cycle register-file destination mux, for the pipelined datapath. Selects the write-back register address from rt, rd or the link register, or marks "no write". Carries address and write-enable through DEPTH pipeline stages with stall and flush. Exposes per-stage compare results so the hazard/forwarding unit can detect read-after-write dependencies.

## Interface
Parameters:
- AW, 5, register address width
- DEPTH, 3, in-flight stages tracked (stage 0 = EX, DEPTH-1 = WB); legal 2..8
- LINK_REG, 31, destination used in link mode (jal)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- dst_sel  in  2  00 rt (lw/I-type), 01 rd (R-type), 10 LINK_REG, 11 no write
- rt  in  AW  rt field of instruction in decode
- rd  in  AW  rd field of instruction in decode
- reg_write  in  1  decode-stage RegWrite control
- stall  in  1  load-use stall: hold stage 0, bubble into stage 1
- flush  in  1  squash instruction entering stage 0
- rs_src  in  AW  source rs of instruction in decode
- rt_src  in  AW  source rt of instruction in decode
- stage_dst  out  DEPTH*AW  destination of stage i at bits [i*AW +: AW]
- stage_we  out  DEPTH  write-enable of stage i
- wb_addr  out  AW  equals stage_dst of stage DEPTH-1 (to RF write address)
- wb_we  out  1  equals stage_we[DEPTH-1] (to RF write enable)
- haz_rs  out  DEPTH  haz_rs[i]: stage i writes rs_src
- haz_rt  out  DEPTH  haz_rt[i]: stage i writes rt_src
- inflight  out  clog2(DEPTH+1)  count of stages with stage_we=1

## Operation
- Decode-side selection, combinational: sel_addr = rt / rd / LINK_REG / 0 for dst_sel 00/01/10/11.
- sel_we = reg_write && dst_sel!=11 && sel_addr!=0. Writes to $0 are never tracked or issued.
- Stage 0 next value:
  - flush=1: we=0, dst=0. Flush has priority over stall.
  - else stall=1: hold current contents.
  - else: {sel_addr, sel_we}.
- Stage 1 next value:
  - stall=1 and flush=0: bubble (we=0, dst=0).
  - otherwise: stage 0 contents.
- Stages 2..DEPTH-1 always shift from stage i-1. Stall does not freeze them.
- Hazard compares, combinational from registered state:
  - haz_rs[i] = stage_we[i] && stage_dst[i]==rs_src && rs_src!=0. haz_rt is identical using rt_src.
  - Multiple bits may be set; priority (youngest stage wins) is the forwarding unit's job.
- inflight = popcount(stage_we), combinational.
- dst for a bubble is always 0. dst for a valid stage with we=0 (dst_sel=11 or reg_write=0) holds the selected address, but consumers ignore it.

## Timing
- Reset (rst_n=0 at a rising edge): all stage_dst=0, stage_we=0, so wb_addr=0, wb_we=0, haz_rs=haz_rt=0 and inflight=0 after that edge. Reset overrides stall and flush. Reset mid-stream discards all in-flight entries.
- Latency: a decode instruction sampled at edge N appears in stage 0 after edge N and on wb_addr/wb_we after edge N+DEPTH-1, with no stall or flush.
- Each cycle stall is asserted adds one cycle to the latency of the instruction held in stage 0. A stall lasting K cycles inserts K bubbles into stage 1.
- stall and flush together: stage 0 is squashed and stage 1 still receives the old stage 0 contents (no bubble), i.e. flush wins.
- Hazard outputs are valid in the same cycle as the rs_src/rt_src inputs, with no register delay.
- No combinational path from dst_sel, rt or rd to any output.

## Test plan
- Reset: drive stage contents nonzero, then rst_n=0 for one edge → stage_we=0, wb_we=0, inflight=0; with stall=1 held during reset, all outputs are still zero.
- Mode select (DEPTH=3): issue dst_sel=01 rd=9, then 00 rt=4, then 10, on consecutive cycles, reg_write=1 → wb_addr=9, then 4, then 31 on edges N+2, N+3, N+4, with wb_we=1 each.
- $0 and no-write: rd=0 with dst_sel=01, then dst_sel=11 with rt=7 → stage_we=0 for both; inflight never increments; haz_rs=0 even with rs_src=0.
- Stall: instruction rd=12 in stage 0, stall=1 for 2 cycles → stage 0 holds 12, stage 1 receives 2 bubbles, wb_addr=12 at N+4 instead of N+2.
- Flush vs stall: stall=1 and flush=1 in the same cycle with stage 0 holding rd=5 → stage 0 becomes bubble, stage 1 becomes dst=5 we=1.
- Hazard: stages hold dst 8, 8, 3 (all we=1); rs_src=8, rt_src=3 → haz_rs=3'b011, haz_rt=3'b100, inflight=3.
